// File: rtl/dmem_ram_stream.sv
// Word-addressed data memory: asynchronous CPU read, synchronous CPU write, full-array dump engine.
// Build option: define DMEM_WRITE_GUARD_EN to drop CPU writes while a dump is in progress.
module dmem_ram_stream #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 129600,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] rd,
  output logic              werr,
  input  logic              dump_start,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [DATA_W-1:0] dump_data,
  output logic [CNT_W-1:0]  dump_addr,
  output logic              dump_busy,
  output logic              dump_done
);

  localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
  localparam logic [CNT_W-1:0]  LAST_C  = CNT_W'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_PRESENT, S_DONE} state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_data;
  logic [CNT_W-1:0]  r_addr;
  logic              r_valid;
  logic              r_busy;
  logic              r_done;
  logic              r_werr;

  logic              w_in_range;
  logic              w_guard;
  logic              w_wr_ok;
  logic [IDX_W-1:0]  w_cpu_idx;
  logic [IDX_W-1:0]  w_dump_idx;

  assign w_in_range = (address < DEPTH_A);
  assign w_cpu_idx  = address[IDX_W-1:0];
  assign w_dump_idx = r_cnt[IDX_W-1:0];

`ifdef DMEM_WRITE_GUARD_EN
  assign w_guard = r_busy;
`else
  assign w_guard = 1'b0;
`endif

  assign w_wr_ok = we && w_in_range && !w_guard;
  assign rd      = w_in_range ? r_mem[w_cpu_idx] : '0;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[w_cpu_idx] <= wd;
  end

  always_ff @(posedge clk) begin
    if (rst) r_werr <= 1'b0;
    else     r_werr <= we && !w_wr_ok;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_data  <= '0;
      r_addr  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (dump_start) begin
            r_state <= S_FETCH;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        // Old contents are captured when a CPU write hits the same word this cycle.
        S_FETCH: begin
          r_data  <= r_mem[w_dump_idx];
          r_addr  <= r_cnt;
          r_valid <= 1'b1;
          r_state <= S_PRESENT;
        end
        S_PRESENT: begin
          if (dump_ready) begin
            r_valid <= 1'b0;
            if (r_cnt == LAST_C) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_cnt   <= r_cnt + 1'b1;
              r_state <= S_FETCH;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign werr       = r_werr;
  assign dump_valid = r_valid;
  assign dump_data  = r_data;
  assign dump_addr  = r_addr;
  assign dump_busy  = r_busy;
  assign dump_done  = r_done;

endmodule

// File: tb/tb_dmem_ram_stream.sv
// Directed bench for dmem_ram_stream (DEPTH=16): CPU port, out-of-range writes and dump scoreboard.
module tb_dmem_ram_stream;
  localparam int DW  = 32;
  localparam int DEP = 16;
  localparam int AW  = 32;
  localparam int CW  = 4;

`ifdef DMEM_WRITE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          we;
  logic [AW-1:0] address;
  logic [DW-1:0] wd;
  logic [DW-1:0] rd;
  logic          werr;
  logic          dump_start;
  logic          dump_valid;
  logic          dump_ready;
  logic [DW-1:0] dump_data;
  logic [CW-1:0] dump_addr;
  logic          dump_busy;
  logic          dump_done;

  typedef struct packed {
    logic [CW-1:0] a;
    logic [DW-1:0] d;
  } beat_t;

  beat_t         exp_q[$];
  logic [DW-1:0] model [DEP];
  int            checks = 0;
  int            errors = 0;

  dmem_ram_stream #(.DATA_W(DW), .DEPTH(DEP), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .we(we), .address(address), .wd(wd), .rd(rd), .werr(werr),
    .dump_start(dump_start), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_data(dump_data), .dump_addr(dump_addr), .dump_busy(dump_busy), .dump_done(dump_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input int a, input logic [DW-1:0] d);
    address = AW'(a);
    wd      = d;
    we      = 1'b1;
    tick();
    we = 1'b0;
    if (a < DEP) model[a] = d;
  endtask

  // Each dumped word is pushed from the model at dump start and popped on its handshake.
  task automatic run_dump(input int stall_addr, input int stall_n, input int rst_addr,
                          input int wr_edge, input int wr_addr, input logic [DW-1:0] wr_data);
    int    edges, done_edge, beats, stalls;
    bit    aborted, wr_pending, late_done;
    beat_t e;
    edges = 0; done_edge = -1; beats = 0; stalls = 0;
    aborted = 1'b0; wr_pending = 1'b0; late_done = 1'b0;
    if (wr_edge >= 0 && !GUARD) model[wr_addr] = wr_data;
    exp_q.delete();
    for (int i = 0; i < DEP; i++) exp_q.push_back({CW'(i), model[i]});
    dump_ready = 1'b1;
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    while (edges < 200 && done_edge < 0 && !aborted) begin
      if (wr_pending) begin
        we = 1'b0;
        wr_pending = 1'b0;
        check("werr_during_dump", werr, GUARD);
      end
      if (edges == wr_edge) begin
        we = 1'b1; address = AW'(wr_addr); wd = wr_data; wr_pending = 1'b1;
      end
      if (dump_done) begin
        done_edge = edges;
      end else if (dump_valid) begin
        if (dump_addr == rst_addr) begin
          dump_ready = 1'b0;
          rst = 1'b1;
          tick();
          rst = 1'b0;
          check("rst_valid", dump_valid, 0);
          check("rst_busy", dump_busy, 0);
          check("rst_done", dump_done, 0);
          aborted = 1'b1;
        end else if (dump_addr == stall_addr && stalls < stall_n) begin
          dump_ready = 1'b0;
          stalls++;
          check("stall_data", dump_data, exp_q[0].d);
          check("stall_addr", dump_addr, exp_q[0].a);
        end else begin
          dump_ready = 1'b1;
          if (exp_q.size() == 0) begin
            check("extra_beat", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("beat_addr", dump_addr, e.a);
            check("beat_data", dump_data, e.d);
            beats++;
          end
        end
      end
      if (!aborted && done_edge < 0) begin
        tick();
        edges++;
      end
    end
    if (aborted) begin
      for (int i = 0; i < 4; i++) begin
        tick();
        if (dump_done || dump_busy) late_done = 1'b1;
      end
      check("no_done_after_rst", late_done, 0);
      exp_q.delete();
    end else begin
      check("done_edge", done_edge, 2 * DEP + stall_n);
      check("beats", beats, DEP);
      check("queue_empty", exp_q.size(), 0);
      check("busy_at_done", dump_busy, 0);
      tick();
      check("done_one_cycle", dump_done, 0);
      check("valid_after_done", dump_valid, 0);
    end
    dump_ready = 1'b0;
    we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; address = '0; wd = '0; dump_start = 1'b0; dump_ready = 1'b0;
    tick();
    tick();
    check("rst_werr", werr, 0);
    check("rst_dump_valid", dump_valid, 0);
    check("rst_dump_busy", dump_busy, 0);
    check("rst_dump_done", dump_done, 0);
    check("rst_dump_addr", dump_addr, 0);
    check("rst_dump_data", dump_data, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < DEP; i++) cpu_write(i, i * 32'h11);
    cpu_write(3, 32'hA5A5_0003);
    address = 3;  #1; check("rd_addr3", rd, 32'hA5A5_0003);
    address = 16; #1; check("rd_oob16", rd, 0);
    address = 15; #1; check("rd_last", rd, 32'hFF);
    cpu_write(3, 32'h33);

    cpu_write(20, 32'h1234_5678);
    check("werr_oob", werr, 1);
    tick();
    check("werr_pulse_end", werr, 0);
    for (int i = 0; i < DEP; i++) begin
      address = AW'(i);
      #1;
      check("mem_after_oob", rd, model[i]);
    end

    run_dump(-1, 0, -1, -1, 0, '0);
    run_dump(7, 5, -1, -1, 0, '0);
    run_dump(-1, 0, 9, -1, 0, '0);
    run_dump(-1, 0, -1, -1, 0, '0);
    run_dump(-1, 0, -1, 5, 12, 32'hDEAD);
    address = 12; #1; check("rd12_after_dump", rd, model[12]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
